// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and helpers for the single- and dual-clock FIFOs
//
// Purpose:
//   Common definitions imported by the FIFO family:
//   - fifo_mode_e    : read-port mode (standard registered read or FWFT)
//   - level_width()  : width of an occupancy counter that holds 0..size
//   - fifo_params_ok : parameter legality check, evaluated at elaboration
// Ports: none (package).

package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  // Bits needed to represent every level from 0 to size inclusive.
  function automatic int level_width(input int size);
    return $clog2(size + 1);
  endfunction

  // Legal when the entry width is non-zero, there are at least two entries,
  // the mode is 0/1, and both thresholds fall inside the reachable levels.
  function automatic bit fifo_params_ok(
    input int bits,
    input int size,
    input int fwft,
    input int af_th,
    input int ae_th
  );
    return (bits >= 1) &&
           (size >= 2) &&
           ((fwft == 0) || (fwft == 1)) &&
           (af_th >= 1) && (af_th <= size) &&
           (ae_th >= 0) && (ae_th <= size - 1);
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// rtl/fifo_ptr.sv - wrapping index counter 0..SIZE-1 for FIFO storage
//
// Purpose:
//   Advances by one on each cycle that inc is high and wraps explicitly from
//   SIZE-1 back to 0, so SIZE need not be a power of two.
// Ports:
//   clk   in   clock, rising edge
//   rst_n in   asynchronous active-low reset, pointer returns to 0
//   inc   in   advance the pointer this cycle
//   ptr   out  current index, $clog2(SIZE) bits

module fifo_ptr #(
  parameter int SIZE = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    inc,
  output logic [$clog2(SIZE)-1:0] ptr
);

  localparam int PW = $clog2(SIZE);
  localparam logic [PW-1:0] LAST = PW'(SIZE - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (inc) begin
      if (ptr == LAST) begin
        ptr <= '0;
      end else begin
        ptr <= ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO, any depth, standard or FWFT read port
//
// Purpose:
//   Same-clock buffer between pipeline stages. Occupancy is held in a
//   registered level counter and every status flag is decoded from it, so
//   flags and p_level move on the same edge as the transfer that changed them.
//   Optional error flags are built when SYNC_FIFO_ERR_EN is defined.
// Ports:
//   clk                  in   clock, rising edge
//   rst_n                in   asynchronous active-low reset
//   p_write_en           in   write request
//   p_write_data         in   write data, BITS
//   p_write_full         out  level == SIZE
//   p_write_almost_full  out  level >= ALMOST_FULL_TH
//   p_read_en            in   read request (pop/acknowledge in FWFT mode)
//   p_read_data          out  read data, BITS
//   p_read_empty         out  level == 0
//   p_read_almost_empty  out  level <= ALMOST_EMPTY_TH
//   p_level              out  occupancy 0..SIZE
//   p_err_clr            in   (SYNC_FIFO_ERR_EN) synchronous clear of error flags
//   p_overflow           out  (SYNC_FIFO_ERR_EN) sticky: write attempted while full
//   p_underflow          out  (SYNC_FIFO_ERR_EN) sticky: read attempted while empty

module sync_fifo
  import fifo_pkg::*;
#(
  parameter int BITS            = 32,
  parameter int SIZE            = 16,
  parameter int FWFT            = 0,
  parameter int ALMOST_FULL_TH  = SIZE - 2,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      p_write_en,
  input  logic [BITS-1:0]           p_write_data,
  output logic                      p_write_full,
  output logic                      p_write_almost_full,
  input  logic                      p_read_en,
  output logic [BITS-1:0]           p_read_data,
  output logic                      p_read_empty,
  output logic                      p_read_almost_empty,
  output logic [$clog2(SIZE+1)-1:0] p_level
`ifdef SYNC_FIFO_ERR_EN
  ,
  input  logic                      p_err_clr,
  output logic                      p_overflow,
  output logic                      p_underflow
`endif
);

  localparam int LW = level_width(SIZE);
  localparam int PW = $clog2(SIZE);
  localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

  localparam logic [LW-1:0] LVL_FULL = LW'(SIZE);
  localparam logic [LW-1:0] AF_TH    = LW'(ALMOST_FULL_TH);
  localparam logic [LW-1:0] AE_TH    = LW'(ALMOST_EMPTY_TH);

  generate
    if (!fifo_params_ok(BITS, SIZE, FWFT, ALMOST_FULL_TH, ALMOST_EMPTY_TH)) begin : g_bad_params
      $error("sync_fifo: illegal parameter combination");
    end
  endgenerate

  logic [BITS-1:0] mem [SIZE];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [LW-1:0]   level;
  logic            full;
  logic            empty;
  logic            wr_acc;
  logic            rd_acc;

  // Flags come from the pre-edge level, so a full FIFO never accepts a
  // write even if a read is accepted in the same cycle, and vice versa.
  assign full   = (level == LVL_FULL);
  assign empty  = (level == '0);
  assign wr_acc = p_write_en && !full;
  assign rd_acc = p_read_en && !empty;

  fifo_ptr #(
    .SIZE (SIZE)
  ) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (wr_acc),
    .ptr   (wr_ptr)
  );

  fifo_ptr #(
    .SIZE (SIZE)
  ) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (rd_acc),
    .ptr   (rd_ptr)
  );

  // Storage is deliberately left out of reset; level gates every use of it.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= p_write_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= '0;
    end else begin
      unique case ({wr_acc, rd_acc})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign p_level             = level;
  assign p_write_full        = full;
  assign p_read_empty        = empty;
  assign p_write_almost_full = (level >= AF_TH);
  assign p_read_almost_empty = (level <= AE_TH);

  generate
    if (MODE == FIFO_FWFT) begin : g_fwft
      // Head entry is presented directly; zero while empty so stale or
      // never-written storage is not exposed.
      assign p_read_data = empty ? '0 : mem[rd_ptr];
    end else begin : g_std
      logic [BITS-1:0] rd_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_q <= '0;
        end else if (rd_acc) begin
          rd_q <= mem[rd_ptr];
        end
      end

      assign p_read_data = rd_q;
    end
  endgenerate

`ifdef SYNC_FIFO_ERR_EN
  // Set wins over clear so an illegal request in the clearing cycle is
  // not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_overflow  <= 1'b0;
      p_underflow <= 1'b0;
    end else begin
      if (p_write_en && full) begin
        p_overflow <= 1'b1;
      end else if (p_err_clr) begin
        p_overflow <= 1'b0;
      end

      if (p_read_en && empty) begin
        p_underflow <= 1'b1;
      end else if (p_err_clr) begin
        p_underflow <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
Single-clock FIFO; the single-clock successor to the team's dual-clock FIFO, for paths where producer and consumer share a clock.
- Generalised: any depth (not only power-of-two), selectable standard or first-word-fall-through (FWFT) read mode, programmable almost-full/almost-empty thresholds, exact occupancy output.
- Sits between same-clock pipeline stages and in front of the dual-clock FIFO as a rate-smoothing buffer.

Parameters:
BITS, 32, width of each entry (>=1)
SIZE, 16, number of entries (>=2, any integer)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
ALMOST_FULL_TH, SIZE-2, p_write_almost_full asserts when level >= this value (1..SIZE)
ALMOST_EMPTY_TH, 2, p_read_almost_empty asserts when level <= this value (0..SIZE-1)

Ports:
clk  input  1  clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
p_write_en  input  1  write request
p_write_data  input  BITS  write data
p_write_full  output  1  level == SIZE
p_write_almost_full  output  1  level >= ALMOST_FULL_TH
p_read_en  input  1  read request
p_read_data  output  BITS  read data
p_read_empty  output  1  level == 0
p_read_almost_empty  output  1  level <= ALMOST_EMPTY_TH
p_level  output  $clog2(SIZE+1)  current occupancy 0..SIZE

Behaviour:
- Reset (async assert, sync release): pointers = 0, level = 0, p_read_data = 0, full = 0, empty = 1, almost_empty = 1, almost_full = 0. Storage array is not reset.
- Write accepted iff p_write_en && !p_write_full. Write while full is dropped; no state change.
- Read accepted iff p_read_en && !p_read_empty. Read while empty is ignored; p_read_data unchanged.
- Pointers range 0..SIZE-1 with explicit wrap (SIZE-1 -> 0); no power-of-two modulo.
- Level is a registered counter, all flags decoded from it:
  - write only: +1
  - read only: -1
  - both accepted: unchanged, both pointers advance
- Full and empty are evaluated on the pre-edge level. No write-through when full; no read-through when empty.
- Flags and p_level update on the same edge as the accepting transfer (one-cycle visibility).
- FWFT=0: p_read_data registered; valid data appears on the cycle after an accepted read, then holds until the next accepted read.
- FWFT=1:
  - p_read_data = entry at read pointer, combinationally, whenever !p_read_empty; forced to 0 while empty.
  - p_read_en acts as the pop/acknowledge.
  - A write into an empty FIFO is visible on p_read_data the cycle after the write edge.
- Wrap-around: both pointers cross SIZE-1 -> 0 independently. Level stays exact across wraps.
- Reset mid-operation: all contents are discarded; outputs return to reset values immediately.

Optional Feature:
Macro SYNC_FIFO_ERR_EN.
- Defined: adds ports p_err_clr (input, 1), p_overflow (output, 1), p_underflow (output, 1).
  - p_overflow sets on the edge after p_write_en while full.
  - p_underflow sets on the edge after p_read_en while empty.
  - Both are sticky until rst_n or p_err_clr.
  - p_err_clr is synchronous; set has priority over clear in the same cycle.
- Not defined: ports and logic absent; illegal requests are silently dropped as described above.

Decomposition:
- Package fifo_pkg:
  - function returning level width $clog2(SIZE+1)
  - typedef for the FWFT mode enum (FIFO_STD, FIFO_FWFT)
  - parameter-legality checks reused by the dual-clock FIFO
- Sub-module fifo_ptr: wrapping pointer with parameter SIZE, inputs clk, rst_n, inc; output ptr. Instantiated twice (write and read pointers).

Test Plan:
- SIZE=5, FWFT=0: write 0x11..0x55 in 5 cycles -> full=1 after 5th edge, level=5; a 6th write of 0x66 is dropped; reading 5 returns 0x11..0x55 one cycle after each read, then empty=1, level=0.
- SIZE=5 wrap: 3 writes, 3 reads, 4 writes, 4 reads -> data order preserved across pointer wrap 4->0; level never exceeds 4.
- Simultaneous read+write at level=2 for 10 cycles -> level stays 2; at full (level=5), read+write -> write dropped, level=4; at empty, read+write -> read ignored, level=1.
- FWFT=1: write 0xA5 into empty -> next cycle empty=0, p_read_data=0xA5 with no read; p_read_en=1 -> empty=1 and p_read_data=0 next cycle.
- Thresholds SIZE=16, ALMOST_FULL_TH=14, ALMOST_EMPTY_TH=2: almost_empty deasserts at level 3; almost_full asserts at level 14 and deasserts when level drops to 13.
- rst_n pulsed low mid-stream at level=7 -> level=0, empty=1, p_read_data=0 asynchronously. With SYNC_FIFO_ERR_EN: write when full -> p_overflow=1 and held until p_err_clr.
